rgb_to_colour: RTL and testbench

- Streaming decoder: the reverse of the team's 3-bit colour to 24-bit RGB converter.
- Quantises each incoming 24-bit RGB pixel to the 3-bit colour code (bit 2 = red, bit 1 = green, bit 0 = blue).
- Flags whether the pixel was an exact primary/secondary value.
- Valid/ready on both sides, 2-entry output buffer, running pixel counter. Sits between a pixel source and the colour-code consumer.

---
 rtl/rgb_to_colour_if.sv | 31 +++
 rtl/rgb_to_colour.sv | 83 ++++++++
 tb/tb_rgb_to_colour.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_to_colour_if.sv
// Pixel-in / colour-out handshake bundle for rgb_to_colour.
// The slave modport is the decoder; the master modport is the source and consumer side.
interface rgb_to_colour_if;
    logic [23:0] in_rgb;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  out_colour;
    logic        out_exact;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output in_rgb,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_colour,
        input  out_exact,
        input  out_valid
    );

    modport slave (
        input  in_rgb,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_colour,
        output out_exact,
        output out_valid
    );
endinterface

// File: rtl/rgb_to_colour.sv
// Streaming 24-bit RGB to 3-bit colour-code quantiser.
// Results sit in a 2-entry FIFO; a running counter tracks accepted pixels.
module rgb_to_colour #(
    parameter logic [7:0]  THRESH = 8'h80,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    rgb_to_colour_if.slave   bus,
    output logic [CNT_W-1:0] pixel_count
);

    logic [7:0]       red;
    logic [7:0]       green;
    logic [7:0]       blue;
    logic [3:0]       dec_entry;
    logic [3:0]       head_q;
    logic [3:0]       tail_q;
    logic [1:0]       count_q;
    logic [CNT_W-1:0] pixel_count_q;
    logic             push;
    logic             pop;

    function automatic logic is_rail(input logic [7:0] v);
        return (v == 8'h00) || (v == 8'hFF);
    endfunction

    assign red   = bus.in_rgb[23:16];
    assign green = bus.in_rgb[15:8];
    assign blue  = bus.in_rgb[7:0];

    // Entry layout: {colour[2:0], exact}.
    assign dec_entry = {(red >= THRESH), (green >= THRESH), (blue >= THRESH),
                        is_rail(red) & is_rail(green) & is_rail(blue)};

    // in_ready depends only on local state so out_ready never reaches it combinationally.
    assign bus.in_ready   = enable & ~rst & (count_q != 2'd2);
    assign bus.out_valid  = (count_q != 2'd0);
    assign bus.out_colour = head_q[3:1];
    assign bus.out_exact  = head_q[0];
    assign pixel_count    = pixel_count_q;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q       <= 2'd0;
            head_q        <= 4'd0;
            tail_q        <= 4'd0;
            pixel_count_q <= '0;
        end else begin
            if (push) begin
                pixel_count_q <= pixel_count_q + CNT_W'(1);
            end
            case ({push, pop})
                2'b10: begin
                    count_q <= count_q + 2'd1;
                    if (count_q == 2'd0) begin
                        head_q <= dec_entry;
                    end else begin
                        tail_q <= dec_entry;
                    end
                end
                2'b01: begin
                    count_q <= count_q - 2'd1;
                    // Draining the last entry leaves head_q untouched so outputs hold.
                    if (count_q == 2'd2) begin
                        head_q <= tail_q;
                    end
                end
                2'b11: begin
                    // Only reachable with one entry: the new pixel replaces the head.
                    head_q <= dec_entry;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_to_colour.sv
// Scoreboard bench for rgb_to_colour: driver queues expected codes on acceptance,
// a negedge monitor checks handshake, head entry and counter against the reference.
module tb_rgb_to_colour;

    localparam logic [7:0] THRESH = 8'h80;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] pixel_count;
    logic        w_rst = 1'b1;
    logic [3:0]  w_count;

    rgb_to_colour_if bus ();
    rgb_to_colour_if wbus ();

    rgb_to_colour dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .bus         (bus),
        .pixel_count (pixel_count)
    );

    rgb_to_colour #(.CNT_W(4)) dut_w (
        .clk         (clk),
        .rst         (w_rst),
        .enable      (1'b1),
        .bus         (wbus),
        .pixel_count (w_count)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [3:0]  exp_q[$];
    logic [15:0] exp_pc = 16'd0;
    logic [3:0]  last_out = 4'd0;
    bit          rnd_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each channel thresholded independently, exact when all channels are rails.
    function automatic logic [3:0] model(input logic [23:0] p);
        int r;
        int g;
        int b;
        logic e;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        e = (r == 0 || r == 255) && (g == 0 || g == 255) && (b == 0 || b == 255);
        return {(r >= int'(THRESH)), (g >= int'(THRESH)), (b >= int'(THRESH)), e};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready_in_rst", 32'(bus.in_ready), 32'd0);
            exp_q.delete();
            exp_pc   = 16'd0;
            last_out = 4'd0;
        end else begin
            chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            chk("in_ready", 32'(bus.in_ready), 32'(enable && exp_q.size() < 2));
            chk("pixel_count", 32'(pixel_count), 32'(exp_pc));
            if (exp_q.size() == 0) begin
                chk("held_output", 32'({bus.out_colour, bus.out_exact}), 32'(last_out));
            end else begin
                chk("head_entry", 32'({bus.out_colour, bus.out_exact}), 32'(exp_q[0]));
                if (bus.out_valid && bus.out_ready) begin
                    last_out = exp_q.pop_front();
                end
            end
        end
    end

    task automatic send(input logic [23:0] p);
        bit acc;
        acc = 1'b0;
        bus.in_rgb   = p;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back(model(p));
                exp_pc++;
            end
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_rgb   = 24'($urandom);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: pixel %06h never accepted", p);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) cycles(1);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
    endtask

    function automatic logic [7:0] rnd_chan();
        case ($urandom_range(0, 4))
            0: return 8'h00;
            1: return 8'hFF;
            2: return THRESH - 8'd1;
            3: return THRESH;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] codes [8];
        int pushes;
        bit acc;
        codes = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                  24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};
        bus.in_valid   = 1'b0;
        bus.in_rgb     = 24'd0;
        bus.out_ready  = 1'b0;
        wbus.in_valid  = 1'b0;
        wbus.in_rgb    = 24'd0;
        wbus.out_ready = 1'b1;
        cycles(2);
        rst    = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_colour", 32'(bus.out_colour), 32'd0);
        chk("reset_out_exact", 32'(bus.out_exact), 32'd0);
        chk("reset_pixel_count", 32'(pixel_count), 32'd0);
        cycles(1);

        // All eight codes back-to-back.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(codes[i]);
        drain();
        chk("t1_pixel_count", 32'(pixel_count), 32'd8);
        chk("t1_last_colour", 32'(bus.out_colour), 32'd7);

        // Threshold edges.
        send(24'h7F7F7F);
        send(24'h808080);
        send(24'h80007F);
        drain();
        chk("t2_last_colour", 32'(bus.out_colour), 32'd4);

        // Backpressure.
        bus.out_ready = 1'b0;
        send(24'hFF0000);
        send(24'h00FF00);
        fork
            send(24'h0000FF);
        join_none
        cycles(3);
        @(negedge clk);
        chk("t3_in_ready_full", 32'(bus.in_ready), 32'd0);
        chk("t3_head_held", 32'(bus.out_colour), 32'd4);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait fork;
        drain();
        chk("t3_pixel_count", 32'(pixel_count), 32'd14);

        // Enable gating with one buffered entry draining.
        bus.out_ready = 1'b0;
        send(24'hFF00FF);
        enable        = 1'b0;
        bus.out_ready = 1'b1;
        fork
            send(24'h00FFFF);
        join_none
        repeat (4) begin
            @(negedge clk);
            chk("t4_pixel_count_gated", 32'(pixel_count), 32'd15);
        end
        @(posedge clk);
        #1;
        enable = 1'b1;
        wait fork;
        drain();
        chk("t4_pixel_count", 32'(pixel_count), 32'd16);
        chk("t4_colour", 32'(bus.out_colour), 32'd3);

        // Reset with a full buffer.
        pulse_rst();
        for (int i = 0; i < 3; i++) send(codes[i + 3]);
        drain();
        bus.out_ready = 1'b0;
        send(24'hFFFF00);
        send(24'h00FF00);
        @(negedge clk);
        chk("t5_pixel_count_pre", 32'(pixel_count), 32'd5);
        chk("t5_full", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        pulse_rst();
        @(negedge clk);
        chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_out_colour", 32'(bus.out_colour), 32'd0);
        chk("t5_pixel_count", 32'(pixel_count), 32'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        cycles(5);

        // Random traffic with random backpressure and enable.
        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                enable        = ($urandom_range(0, 4) != 0);
                cycles(1);
            end
        join_none
        for (int i = 0; i < 150; i++) send({rnd_chan(), rnd_chan(), rnd_chan()});
        rnd_on = 1'b0;
        cycles(2);
        bus.out_ready = 1'b1;
        enable        = 1'b1;
        drain();

        // Counter wrap on the 4-bit instance.
        w_rst = 1'b0;
        cycles(1);
        wbus.in_valid = 1'b1;
        pushes = 0;
        for (int i = 0; i < 80 && pushes < 17; i++) begin
            @(negedge clk);
            acc = wbus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                pushes++;
                if (pushes == 17) wbus.in_valid = 1'b0;
                if (pushes >= 15) chk($sformatf("wrap_after_%0d", pushes), 32'(w_count),
                                      32'(pushes % 16));
            end
        end
        chk("wrap_push_total", 32'(pushes), 32'd17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
